// File: rtl/gumnut_port_hub.sv
`default_nettype none
// gumnut_port_hub: N-channel I/O port block on the Gumnut port bus with edge-capture interrupts.
// Rev 1.0
module gumnut_port_hub #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter int                N_CH      = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                WAIT_CYC  = 0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     clkEn_i,
  input  logic                                     port_cyc_i,
  input  logic                                     port_stb_i,
  input  logic                                     port_we_i,
  input  logic [ADDR_W-1:0]                        port_adr_i,
  input  logic [DATA_W-1:0]                        port_dat_i,
  output logic [DATA_W-1:0]                        port_dat_o,
  output logic                                     port_ack_o,
  input  logic [N_CH*DATA_W-1:0]                   ch_in_i,
  output logic [N_CH*DATA_W-1:0]                   ch_out_o,
  output logic                                     int_req_o,
  input  logic                                     int_ack_i,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] int_vec_o
);

  localparam int         VEC_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  typedef enum logic [1:0] {B_IDLE, B_WAIT, B_ACK, B_DONE} bus_state_t;
  typedef enum logic [1:0] {I_IDLE, I_REQ, I_SERV} irq_state_t;

  bus_state_t bus_state;
  irq_state_t irq_state;
  logic [3:0] wait_cnt;
  logic [1:0] arm_cnt;

  logic [N_CH-1:0][DATA_W-1:0] out_reg;
  logic [N_CH-1:0][DATA_W-1:0] mask_reg;
  logic [N_CH-1:0][DATA_W-1:0] stat_reg;
  logic [N_CH-1:0][DATA_W-1:0] sync1;
  logic [N_CH-1:0][DATA_W-1:0] sync2;
  logic [N_CH-1:0][DATA_W-1:0] prev;
  logic [N_CH-1:0][DATA_W-1:0] rise_set;
  logic [N_CH-1:0][DATA_W-1:0] w1c;
  logic [N_CH-1:0][DATA_W-1:0] stat_next;
  logic [N_CH-1:0]             pend;

  logic [ADDR_W-1:0] rel;
  logic [ADDR_W-3:0] ch_sel;
  logic              hit;
  logic              armed;
  logic              wr_commit;
  logic [DATA_W-1:0] rd_data;
  logic [VEC_W-1:0]  low_idx;

  assign rel       = port_adr_i - BASE_ADDR;
  assign ch_sel    = rel[ADDR_W-1:2];
  assign hit       = (port_adr_i >= BASE_ADDR) && ({2'b00, ch_sel} < ADDR_W'(N_CH));
  // The synchroniser chain and prev register need three enabled clocks to fill after reset.
  assign armed     = (arm_cnt == 2'd3);
  assign wr_commit = (bus_state == B_ACK) && port_we_i && hit;
  assign ch_out_o  = out_reg;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (hit && ch_sel == (ADDR_W-2)'(i)) begin
        case (rel[1:0])
          2'd0:    rd_data = out_reg[i];
          2'd1:    rd_data = sync2[i];
          2'd2:    rd_data = mask_reg[i];
          default: rd_data = stat_reg[i];
        endcase
      end
    end
  end

  // A rising edge landing in the same cycle as a W1C of that bit keeps the bit set.
  always_comb begin
    rise_set  = '0;
    w1c       = '0;
    stat_next = '0;
    pend      = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (armed)
        rise_set[i] = sync2[i] & ~prev[i];
      if (wr_commit && ch_sel == (ADDR_W-2)'(i) && rel[1:0] == 2'd3)
        w1c[i] = port_dat_i;
      stat_next[i] = (stat_reg[i] & ~w1c[i]) | rise_set[i];
      pend[i]      = |(stat_reg[i] & mask_reg[i]);
    end
  end

  always_comb begin
    low_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend[i])
        low_idx = VEC_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_reg  <= '0;
      mask_reg <= '0;
      stat_reg <= '0;
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      arm_cnt  <= '0;
    end else if (clkEn_i) begin
      sync1    <= ch_in_i;
      sync2    <= sync1;
      prev     <= sync2;
      stat_reg <= stat_next;
      if (!armed)
        arm_cnt <= arm_cnt + 2'd1;
      for (int i = 0; i < N_CH; i++) begin
        if (wr_commit && ch_sel == (ADDR_W-2)'(i)) begin
          case (rel[1:0])
            2'd0:    out_reg[i]  <= port_dat_i;
            2'd2:    mask_reg[i] <= port_dat_i;
            default: ;
          endcase
        end
      end
    end
  end

  // The master holds address and data until it sees ack, so decode uses the live bus.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_state  <= B_IDLE;
      wait_cnt   <= '0;
      port_ack_o <= 1'b0;
      port_dat_o <= '0;
    end else if (clkEn_i) begin
      port_ack_o <= 1'b0;
      port_dat_o <= '0;
      case (bus_state)
        B_IDLE: begin
          if (port_cyc_i && port_stb_i) begin
            if (WAIT_CYC == 0) begin
              bus_state  <= B_ACK;
              port_ack_o <= 1'b1;
              port_dat_o <= rd_data;
            end else begin
              bus_state <= B_WAIT;
              wait_cnt  <= WAIT_INIT;
            end
          end
        end
        B_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            bus_state  <= B_ACK;
            port_ack_o <= 1'b1;
            port_dat_o <= rd_data;
          end
        end
        B_ACK:   bus_state <= B_DONE;
        B_DONE:  if (!port_stb_i) bus_state <= B_IDLE;
        default: bus_state <= B_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_state <= I_IDLE;
      int_req_o <= 1'b0;
      int_vec_o <= '0;
    end else if (clkEn_i) begin
      case (irq_state)
        I_IDLE: begin
          if (|pend) begin
            irq_state <= I_REQ;
            int_req_o <= 1'b1;
            int_vec_o <= low_idx;
          end
        end
        I_REQ: begin
          if (int_ack_i) begin
            irq_state <= I_SERV;
            int_req_o <= 1'b0;
          end
        end
        I_SERV:  if (!pend[int_vec_o]) irq_state <= I_IDLE;
        default: irq_state <= I_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gumnut_port_hub.sv
`default_nettype none
// tb_gumnut_port_hub: table, directed and random checks of gumnut_port_hub against a register-map model.
module tb_gumnut_port_hub;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 8;
  localparam int N_CH     = 4;
  localparam int BASE     = 'h20;
  localparam int WAIT_CYC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        clkEn_i;
  logic        port_cyc_i;
  logic        port_stb_i;
  logic        port_we_i;
  logic [7:0]  port_adr_i;
  logic [7:0]  port_dat_i;
  logic [7:0]  port_dat_o;
  logic        port_ack_o;
  logic [31:0] ch_in_i;
  logic [31:0] ch_out_o;
  logic        int_req_o;
  logic        int_ack_i;
  logic [1:0]  int_vec_o;

  gumnut_port_hub #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_CH(N_CH),
    .BASE_ADDR(8'h20), .WAIT_CYC(WAIT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .clkEn_i(clkEn_i),
    .port_cyc_i(port_cyc_i), .port_stb_i(port_stb_i), .port_we_i(port_we_i),
    .port_adr_i(port_adr_i), .port_dat_i(port_dat_i), .port_dat_o(port_dat_o),
    .port_ack_o(port_ack_o), .ch_in_i(ch_in_i), .ch_out_o(ch_out_o),
    .int_req_o(int_req_o), .int_ack_i(int_ack_i), .int_vec_o(int_vec_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  m_out [N_CH];
  logic [7:0]  m_mask[N_CH];
  logic [7:0]  m_stat[N_CH];
  logic [31:0] m_in;

  typedef struct {
    logic       we;
    int         adr;
    logic [7:0] wd;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input int adr);
    int rel;
    int c;
    rel = adr - BASE;
    if (rel < 0 || rel / 4 >= N_CH) return 8'h00;
    c = rel / 4;
    case (rel % 4)
      0:       return m_out[c];
      1:       return m_in[c*8 +: 8];
      2:       return m_mask[c];
      default: return m_stat[c];
    endcase
  endfunction

  task automatic model_write(input int adr, input logic [7:0] wd);
    int rel;
    int c;
    rel = adr - BASE;
    if (rel >= 0 && rel / 4 < N_CH) begin
      c = rel / 4;
      case (rel % 4)
        0:       m_out[c]  = wd;
        2:       m_mask[c] = wd;
        3:       m_stat[c] = m_stat[c] & ~wd;
        default: ;
      endcase
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_out[c]  = 8'h00;
      m_mask[c] = 8'h00;
      m_stat[c] = 8'h00;
    end
  endtask

  function automatic logic [31:0] exp_out();
    return {m_out[3], m_out[2], m_out[1], m_out[0]};
  endfunction

  // Input changes are followed by idle time so the synchronised value has settled.
  task automatic set_inputs(input logic [31:0] v);
    for (int c = 0; c < N_CH; c++)
      m_stat[c] = m_stat[c] | (v[c*8 +: 8] & ~m_in[c*8 +: 8]);
    m_in    = v;
    ch_in_i = v;
    repeat (5) tick();
  endtask

  task automatic bus_xfer(input logic we, input int adr, input logic [7:0] wd,
                          input int hold, output logic [7:0] rd);
    int n;
    int extra;
    port_cyc_i = 1'b1;
    port_stb_i = 1'b1;
    port_we_i  = we;
    port_adr_i = 8'(adr);
    port_dat_i = wd;
    n = 0;
    do begin
      tick();
      n++;
    end while (port_ack_o !== 1'b1 && n < 50);
    chk("bus_latency", n, WAIT_CYC + 1);
    rd = port_dat_o;
    extra = 0;
    for (int k = 0; k < hold + 1; k++) begin
      tick();
      if (port_ack_o) extra++;
    end
    chk("bus_single_ack", extra, 0);
    port_cyc_i = 1'b0;
    port_stb_i = 1'b0;
    port_we_i  = 1'b0;
    tick();
  endtask

  task automatic wait_req(input string name, input int max);
    int n;
    n = 0;
    while (int_req_o !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk(name, int_req_o, 1);
  endtask

  task automatic ack_pulse(input string name);
    int_ack_i = 1'b1;
    tick();
    int_ack_i = 1'b0;
    chk(name, int_req_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    int         n;
    int         acks;
    int         adr;
    int         rel;
    logic       we;
    logic [7:0] wd;
    logic [7:0] exp;

    tbl[0]  = '{1'b1, 'h20, 8'h11, 8'h00};
    tbl[1]  = '{1'b0, 'h20, 8'h00, 8'h11};
    tbl[2]  = '{1'b1, 'h2E, 8'h0F, 8'h00};
    tbl[3]  = '{1'b0, 'h2E, 8'h00, 8'h0F};
    tbl[4]  = '{1'b1, 'h2E, 8'h00, 8'h00};
    tbl[5]  = '{1'b0, 'h2E, 8'h00, 8'h00};
    tbl[6]  = '{1'b0, 'h24, 8'h00, 8'hA5};
    tbl[7]  = '{1'b0, 'h30, 8'h00, 8'h00};
    tbl[8]  = '{1'b1, 'h30, 8'hFF, 8'h00};
    tbl[9]  = '{1'b0, 'h1F, 8'h00, 8'h00};
    tbl[10] = '{1'b1, 'h1F, 8'h77, 8'h00};
    tbl[11] = '{1'b0, 'h25, 8'h00, 8'h3C};
    tbl[12] = '{1'b0, 'h27, 8'h00, 8'h3C};
    tbl[13] = '{1'b1, 'h27, 8'h0C, 8'h00};
    tbl[14] = '{1'b0, 'h27, 8'h00, 8'h30};
    tbl[15] = '{1'b1, 'h2C, 8'hC3, 8'h00};
    tbl[16] = '{1'b0, 'h2C, 8'h00, 8'hC3};

    rst = 1'b0; clkEn_i = 1'b1; port_cyc_i = 1'b0; port_stb_i = 1'b0;
    port_we_i = 1'b0; port_adr_i = 8'h00; port_dat_i = 8'h00;
    ch_in_i = 32'h0; int_ack_i = 1'b0; m_in = 32'h0;
    model_reset();
    repeat (3) tick();
    chk("rst_ch_out", ch_out_o, 0);
    chk("rst_ack", port_ack_o, 0);
    chk("rst_dat", port_dat_o, 0);
    chk("rst_int_req", int_req_o, 0);
    chk("rst_int_vec", int_vec_o, 0);
    rst = 1'b1;
    tick();

    // Basic read, write with held strobe, readback
    bus_xfer(1'b0, BASE, 8'h00, 0, rd);
    chk("t1_read_out0", rd, 8'h00);
    bus_xfer(1'b1, BASE + 4, 8'hA5, 4, rd);
    model_write(BASE + 4, 8'hA5);
    chk("t2_ch_out1", ch_out_o[15:8], 8'hA5);
    bus_xfer(1'b0, BASE + 4, 8'h00, 0, rd);
    chk("t2_readback", rd, 8'hA5);

    // Clock enable low freezes a pending transfer
    clkEn_i = 1'b0;
    port_cyc_i = 1'b1; port_stb_i = 1'b1; port_adr_i = 8'(BASE + 4);
    acks = 0;
    repeat (6) begin
      tick();
      if (port_ack_o) acks++;
    end
    chk("clken_frozen_ack", acks, 0);
    clkEn_i = 1'b1;
    n = 0;
    do begin tick(); n++; end while (port_ack_o !== 1'b1 && n < 50);
    chk("clken_resume_lat", n, WAIT_CYC + 1);
    chk("clken_resume_dat", port_dat_o, 8'hA5);
    tick();
    port_cyc_i = 1'b0; port_stb_i = 1'b0;
    tick();

    // Register-map table
    set_inputs(32'h0000_3C00);
    for (int i = 0; i < 17; i++) begin
      bus_xfer(tbl[i].we, tbl[i].adr, tbl[i].wd, 0, rd);
      if (tbl[i].we) model_write(tbl[i].adr, tbl[i].wd);
      else chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp);
    end
    chk("tbl_ch_out", ch_out_o, exp_out());

    // Random traffic with masks left at zero
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) set_inputs($urandom);
      adr = BASE - 4 + int'($urandom_range(0, 4 * N_CH + 7));
      we  = 1'($urandom_range(0, 1));
      wd  = 8'($urandom);
      rel = adr - BASE;
      if (rel >= 0 && rel / 4 < N_CH && rel % 4 == 2) we = 1'b0;
      exp = model_read(adr);
      bus_xfer(we, adr, wd, 0, rd);
      if (we) model_write(adr, wd);
      else chk("rnd_read", rd, exp);
      chk("rnd_ch_out", ch_out_o, exp_out());
      chk("rnd_no_irq", int_req_o, 0);
    end

    // Clean status before interrupt tests
    set_inputs(32'h0);
    for (int c = 0; c < N_CH; c++) begin
      bus_xfer(1'b1, BASE + 4 * c + 3, 8'hFF, 0, rd);
      model_write(BASE + 4 * c + 3, 8'hFF);
    end

    // Single channel interrupt
    bus_xfer(1'b1, BASE + 10, 8'h01, 0, rd);
    model_write(BASE + 10, 8'h01);
    int_ack_i = 1'b1; tick(); int_ack_i = 1'b0;
    chk("t3_idle_ack_ignored", int_req_o, 0);
    set_inputs(32'h0001_0000);
    wait_req("t3_req", 10);
    chk("t3_vec", int_vec_o, 2);
    repeat (3) tick();
    chk("t3_req_held", int_req_o, 1);
    bus_xfer(1'b0, BASE + 11, 8'h00, 0, rd);
    chk("t3_stat2", rd, 8'h01);
    ack_pulse("t3_req_dropped");
    bus_xfer(1'b1, BASE + 11, 8'h01, 0, rd);
    model_write(BASE + 11, 8'h01);
    acks = 0;
    repeat (6) begin
      tick();
      if (int_req_o) acks++;
    end
    chk("t3_no_rerequest", acks, 0);

    // Two channels pending: lowest index served first, no preemption
    bus_xfer(1'b1, BASE + 6, 8'h01, 0, rd);
    model_write(BASE + 6, 8'h01);
    bus_xfer(1'b1, BASE + 14, 8'h01, 0, rd);
    model_write(BASE + 14, 8'h01);
    set_inputs(32'h0101_0100);
    wait_req("t4_req_a", 10);
    chk("t4_vec_a", int_vec_o, 1);
    ack_pulse("t4_ack_a");
    bus_xfer(1'b1, BASE + 7, 8'h01, 0, rd);
    model_write(BASE + 7, 8'h01);
    wait_req("t4_req_b", 10);
    chk("t4_vec_b", int_vec_o, 3);
    ack_pulse("t4_ack_b");
    bus_xfer(1'b1, BASE + 15, 8'h01, 0, rd);
    model_write(BASE + 15, 8'h01);
    repeat (4) tick();
    chk("t4_idle", int_req_o, 0);

    // Reset during WAIT aborts the held write, which then completes afterwards
    port_cyc_i = 1'b1; port_stb_i = 1'b1; port_we_i = 1'b1;
    port_adr_i = 8'(BASE + 4); port_dat_i = 8'h5A;
    tick();
    rst = 1'b0;
    acks = 0;
    repeat (3) begin
      tick();
      if (port_ack_o) acks++;
    end
    chk("t6_abort_no_ack", acks, 0);
    chk("t6_abort_out", ch_out_o, 0);
    model_reset();
    rst = 1'b1;
    n = 0;
    do begin tick(); n++; end while (port_ack_o !== 1'b1 && n < 50);
    chk("t6_resume_lat", n, WAIT_CYC + 1);
    tick();
    port_cyc_i = 1'b0; port_stb_i = 1'b0; port_we_i = 1'b0;
    tick();
    model_write(BASE + 4, 8'h5A);
    chk("t6_ch_out", ch_out_o, exp_out());
    bus_xfer(1'b0, BASE + 11, 8'h00, 0, rd);
    chk("t6_no_false_edge", rd, model_read(BASE + 11));
    bus_xfer(1'b0, BASE + 9, 8'h00, 0, rd);
    chk("t6_in2", rd, model_read(BASE + 9));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
